// File: rtl/mem_stage.sv
// Pipeline MEM stage: branch resolution, data-memory access over a req/ack
// handshake with timeout, forwarding probe and the MEM/WB pipeline register.
module mem_stage #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic        is_branch,
  input  logic [31:0] pc_branch,
  input  logic        alu_zero,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic        mem_type,
  input  logic        mem_to_reg,
  input  logic [31:0] alu_out,
  input  logic [31:0] data_t,
  input  logic [4:0]  reg_addr,
  input  logic        reg_write,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [3:0]  dmem_be,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        stall,
  output logic        branch_taken,
  output logic [31:0] pc_branch_out,
  output logic [4:0]  reg_probe,
  output logic [31:0] data_probe,
  output logic        write_probe,
  output logic        wb_mem_to_reg,
  output logic        wb_reg_write,
  output logic [4:0]  wb_reg_addr,
  output logic [31:0] wb_alu_out,
  output logic [31:0] wb_mem_data,
  output logic        addr_error,
  output logic        bus_error
);

  localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [CNT_W-1:0] counter_r;
  logic [31:0]      load_data_r;
  logic             timeout_r;

  logic mem_op_s;
  logic misaligned_s;
  logic access_s;

  function automatic logic [3:0] byte_enable(input logic byte_op, input logic [1:0] lane);
    logic [3:0] be;
    if (byte_op) begin
      be = 4'b0001 << lane;
    end else begin
      be = 4'b1111;
    end
    return be;
  endfunction

  function automatic logic [31:0] format_load(input logic byte_op, input logic [1:0] lane,
                                              input logic [31:0] rdata);
    logic [7:0] b;
    case (lane)
      2'd0:    b = rdata[7:0];
      2'd1:    b = rdata[15:8];
      2'd2:    b = rdata[23:16];
      2'd3:    b = rdata[31:24];
      default: b = 8'h00;
    endcase
    if (byte_op) begin
      return {{24{b[7]}}, b};
    end else begin
      return rdata;
    end
  endfunction

  assign mem_op_s     = mem_read | mem_write;
  assign misaligned_s = mem_op_s & ~mem_type & (alu_out[1:0] != 2'b00);
  assign access_s     = mem_op_s & ~misaligned_s;

  // Gated by reset so the freeze releases the moment reset is asserted.
  assign stall = reset & ((state_r == BUSY) | ((state_r == IDLE) & access_s));

  assign branch_taken  = is_branch & alu_zero;
  assign pc_branch_out = pc_branch;
  assign reg_probe     = reg_addr;
  assign data_probe    = ((state_r == DONE) && mem_to_reg) ? load_data_r : alu_out;
  assign write_probe   = reg_write & (~mem_to_reg | (state_r == DONE)) & ~misaligned_s;

  // Access FSM, memory request registers, sticky error flags and MEM/WB register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r       <= IDLE;
      counter_r     <= '0;
      load_data_r   <= 32'd0;
      timeout_r     <= 1'b0;
      dmem_req      <= 1'b0;
      dmem_we       <= 1'b0;
      dmem_addr     <= 32'd0;
      dmem_be       <= 4'd0;
      dmem_wdata    <= 32'd0;
      wb_mem_to_reg <= 1'b0;
      wb_reg_write  <= 1'b0;
      wb_reg_addr   <= 5'd0;
      wb_alu_out    <= 32'd0;
      wb_mem_data   <= 32'd0;
      addr_error    <= 1'b0;
      bus_error     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (access_s) begin
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write;
            dmem_addr  <= {alu_out[31:2], 2'b00};
            dmem_be    <= byte_enable(mem_type, alu_out[1:0]);
            dmem_wdata <= mem_type ? {4{data_t[7:0]}} : data_t;
            counter_r  <= '0;
            timeout_r  <= 1'b0;
            state_r    <= BUSY;
          end else begin
            if (misaligned_s) begin
              addr_error <= 1'b1;
            end
            if (we) begin
              wb_mem_to_reg <= mem_to_reg;
              wb_reg_write  <= reg_write & ~misaligned_s;
              wb_reg_addr   <= reg_addr;
              wb_alu_out    <= alu_out;
              wb_mem_data   <= 32'd0;
            end
          end
        end
        BUSY: begin
          counter_r <= counter_r + CNT_W'(1);
          if (dmem_ack) begin
            load_data_r <= format_load(mem_type, alu_out[1:0], dmem_rdata);
            dmem_req    <= 1'b0;
            state_r     <= DONE;
          end else if (counter_r == CNT_LAST) begin
            bus_error   <= 1'b1;
            timeout_r   <= 1'b1;
            load_data_r <= 32'd0;
            dmem_req    <= 1'b0;
            state_r     <= DONE;
          end
        end
        DONE: begin
          if (we) begin
            wb_mem_to_reg <= mem_to_reg;
            wb_reg_write  <= reg_write & ~timeout_r;
            wb_reg_addr   <= reg_addr;
            wb_alu_out    <= alu_out;
            wb_mem_data   <= load_data_r;
            state_r       <= IDLE;
          end
        end
        default: begin
          state_r  <= IDLE;
          dmem_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage: loads, stores, misalignment,
// ack timeout, asynchronous reset and branch passthrough.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic        is_branch;
  logic [31:0] pc_branch;
  logic        alu_zero;
  logic        mem_read;
  logic        mem_write;
  logic        mem_type;
  logic        mem_to_reg;
  logic [31:0] alu_out;
  logic [31:0] data_t;
  logic [4:0]  reg_addr;
  logic        reg_write;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        stall;
  logic        branch_taken;
  logic [31:0] pc_branch_out;
  logic [4:0]  reg_probe;
  logic [31:0] data_probe;
  logic        write_probe;
  logic        wb_mem_to_reg;
  logic        wb_reg_write;
  logic [4:0]  wb_reg_addr;
  logic [31:0] wb_alu_out;
  logic [31:0] wb_mem_data;
  logic        addr_error;
  logic        bus_error;

  int n_tests = 0;
  int n_fail  = 0;
  int n_stall;
  int n_req;

  mem_stage #(.TIMEOUT(16)) dut (
    .clk(clk), .reset(reset), .we(we), .is_branch(is_branch), .pc_branch(pc_branch),
    .alu_zero(alu_zero), .mem_read(mem_read), .mem_write(mem_write), .mem_type(mem_type),
    .mem_to_reg(mem_to_reg), .alu_out(alu_out), .data_t(data_t), .reg_addr(reg_addr),
    .reg_write(reg_write), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .stall(stall), .branch_taken(branch_taken), .pc_branch_out(pc_branch_out),
    .reg_probe(reg_probe), .data_probe(data_probe), .write_probe(write_probe),
    .wb_mem_to_reg(wb_mem_to_reg), .wb_reg_write(wb_reg_write), .wb_reg_addr(wb_reg_addr),
    .wb_alu_out(wb_alu_out), .wb_mem_data(wb_mem_data), .addr_error(addr_error),
    .bus_error(bus_error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    we = 1'b1; is_branch = 1'b0; pc_branch = 32'd0; alu_zero = 1'b0;
    mem_read = 1'b0; mem_write = 1'b0; mem_type = 1'b0; mem_to_reg = 1'b0;
    alu_out = 32'd0; data_t = 32'd0; reg_addr = 5'd0; reg_write = 1'b0;
    dmem_rdata = 32'd0; dmem_ack = 1'b0;
  endtask

  // Called right after the access inputs are driven at a falling edge; returns
  // in the first non-stalled cycle (DONE), #1 after its falling edge.
  task automatic run_access(input int ack_at, input logic [31:0] rd,
                            output int stalls, output int reqs);
    stalls = 0;
    reqs   = 0;
    for (int i = 0; i < 40; i++) begin
      dmem_ack   = (i == ack_at);
      dmem_rdata = rd;
      #1;
      if (dmem_req) reqs++;
      if (!stall) break;
      stalls++;
      @(negedge clk);
    end
    dmem_ack = 1'b0;
  endtask

  initial begin
    idle_inputs();
    reset = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    check("rst_req", {31'd0, dmem_req}, 32'd0);
    check("rst_stall", {31'd0, stall}, 32'd0);
    check("rst_wb_write", {31'd0, wb_reg_write}, 32'd0);
    check("rst_wb_data", wb_mem_data, 32'd0);
    check("rst_errors", {30'd0, addr_error, bus_error}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);

    // Word load, ack in third BUSY cycle
    mem_read = 1'b1; mem_to_reg = 1'b1; alu_out = 32'h0000_1000; reg_addr = 5'd8; reg_write = 1'b1;
    run_access(3, 32'hDEAD_BEEF, n_stall, n_req);
    check("t1_stall_cycles", n_stall, 32'd4);
    check("t1_req_cycles", n_req, 32'd3);
    check("t1_addr", dmem_addr, 32'h0000_1000);
    check("t1_we_be", {27'd0, dmem_we, dmem_be}, {27'd0, 1'b0, 4'b1111});
    check("t1_data_probe", data_probe, 32'hDEAD_BEEF);
    check("t1_write_probe", {31'd0, write_probe}, 32'd1);
    @(negedge clk);
    idle_inputs();
    #1;
    check("t1_wb_data", wb_mem_data, 32'hDEAD_BEEF);
    check("t1_wb_addr", {27'd0, wb_reg_addr}, 32'd8);
    check("t1_wb_write", {30'd0, wb_reg_write, wb_mem_to_reg}, 32'd3);
    @(negedge clk);

    // Byte store, immediate ack
    mem_write = 1'b1; mem_type = 1'b1; alu_out = 32'h0000_1002; data_t = 32'h0000_00A5;
    run_access(1, 32'd0, n_stall, n_req);
    check("t2_stall_cycles", n_stall, 32'd2);
    check("t2_req_cycles", n_req, 32'd1);
    check("t2_we", {31'd0, dmem_we}, 32'd1);
    check("t2_addr", dmem_addr, 32'h0000_1000);
    check("t2_be", {28'd0, dmem_be}, 32'h0000_0004);
    check("t2_wdata", dmem_wdata, 32'hA5A5_A5A5);
    @(negedge clk);
    idle_inputs();
    @(negedge clk);

    // Byte load, negative lane value
    mem_read = 1'b1; mem_type = 1'b1; mem_to_reg = 1'b1; alu_out = 32'h0000_1003;
    reg_addr = 5'd9; reg_write = 1'b1;
    run_access(1, 32'h80FF_0000, n_stall, n_req);
    check("t3a_stall_cycles", n_stall, 32'd2);
    check("t3a_be", {28'd0, dmem_be}, 32'h0000_0008);
    @(negedge clk);
    idle_inputs();
    #1;
    check("t3a_wb_data", wb_mem_data, 32'hFFFF_FF80);
    check("t3a_wb_write", {31'd0, wb_reg_write}, 32'd1);
    @(negedge clk);

    // Misaligned word load: no request, sticky addr_error
    mem_read = 1'b1; mem_to_reg = 1'b1; alu_out = 32'h0000_1001; reg_addr = 5'd10; reg_write = 1'b1;
    #1;
    check("t4_stall", {31'd0, stall}, 32'd0);
    check("t4_write_probe", {31'd0, write_probe}, 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("t4_req", {31'd0, dmem_req}, 32'd0);
    check("t4_addr_error", {31'd0, addr_error}, 32'd1);
    check("t4_wb_write", {31'd0, wb_reg_write}, 32'd0);
    check("t4_wb_addr", {27'd0, wb_reg_addr}, 32'd10);
    @(negedge clk);
    #1;
    check("t4_addr_error_sticky", {31'd0, addr_error}, 32'd1);

    // Load with no ack: timeout after 16 BUSY cycles
    mem_read = 1'b1; mem_to_reg = 1'b1; alu_out = 32'h0000_2000; reg_addr = 5'd11; reg_write = 1'b1;
    #1;
    check("t5_bus_error_before", {31'd0, bus_error}, 32'd0);
    run_access(-1, 32'h1234_5678, n_stall, n_req);
    check("t5_stall_cycles", n_stall, 32'd17);
    check("t5_req_cycles", n_req, 32'd16);
    check("t5_bus_error", {31'd0, bus_error}, 32'd1);
    check("t5_req_low", {31'd0, dmem_req}, 32'd0);
    @(negedge clk);
    idle_inputs();
    #1;
    check("t5_wb_write", {31'd0, wb_reg_write}, 32'd0);
    check("t5_wb_data", wb_mem_data, 32'd0);
    check("t5_wb_addr", {27'd0, wb_reg_addr}, 32'd11);

    // Stray ack outside BUSY is ignored
    dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    #1;
    check("stray_ack_req", {30'd0, dmem_req, stall}, 32'd0);

    // Pipeline resumes: byte load, positive lane value
    mem_read = 1'b1; mem_type = 1'b1; mem_to_reg = 1'b1; alu_out = 32'h0000_1003;
    reg_addr = 5'd12; reg_write = 1'b1;
    run_access(1, 32'h7F00_0000, n_stall, n_req);
    check("t3b_stall_cycles", n_stall, 32'd2);
    @(negedge clk);
    idle_inputs();
    #1;
    check("t3b_wb_data", wb_mem_data, 32'h0000_007F);
    check("t3b_wb_write", {31'd0, wb_reg_write}, 32'd1);
    check("t3b_bus_error_sticky", {31'd0, bus_error}, 32'd1);
    @(negedge clk);

    // Asynchronous reset in the middle of BUSY
    mem_read = 1'b1; mem_to_reg = 1'b1; alu_out = 32'h0000_3000; reg_addr = 5'd13; reg_write = 1'b1;
    @(negedge clk);
    #1;
    check("t6_busy_req", {30'd0, dmem_req, stall}, 32'd3);
    #1;
    reset = 1'b0;
    #1;
    check("t6_async_drop", {30'd0, dmem_req, stall}, 32'd0);
    check("t6_errors_clear", {30'd0, addr_error, bus_error}, 32'd0);
    check("t6_wb_clear", wb_mem_data, 32'd0);
    is_branch = 1'b1; alu_zero = 1'b1; pc_branch = 32'h0000_0400;
    #1;
    check("t6_branch_taken", {31'd0, branch_taken}, 32'd1);
    check("t6_pc_branch_out", pc_branch_out, 32'h0000_0400);
    alu_zero = 1'b0;
    #1;
    check("t6_branch_not_taken", {31'd0, branch_taken}, 32'd0);
    @(negedge clk);
    idle_inputs();
    reset = 1'b1;
    @(negedge clk);

    // Fresh access after reset starts from IDLE
    mem_read = 1'b1; alu_out = 32'h0000_3000; reg_addr = 5'd14; reg_write = 1'b1;
    run_access(1, 32'h0000_0001, n_stall, n_req);
    check("t6_post_reset_stall", n_stall, 32'd2);
    @(negedge clk);
    idle_inputs();
    #1;
    check("t6_post_reset_wb_addr", {27'd0, wb_reg_addr}, 32'd14);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline MEM stage, directly downstream of the EX stage.
- Consumes the EX/MEM register outputs, resolves the branch decision, and performs data-memory loads and stores over a req/ack handshake. Stalls the pipeline while an access is outstanding.
- Registers results into the MEM/WB register and exposes a forwarding probe, as EX does.

Parameters:
TIMEOUT, 16, max BUSY cycles waiting for dmem_ack before a bus error is flagged (>=2)

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
we  in  1  pipeline write enable from hazard unit
is_branch  in  1  branch instruction
pc_branch  in  32  branch target
alu_zero  in  1  ALU zero flag
mem_read  in  1  load
mem_write  in  1  store
mem_type  in  1  0=word, 1=byte
mem_to_reg  in  1  WB selects memory data
alu_out  in  32  ALU result / effective address
data_t  in  32  store data
reg_addr  in  5  destination register
reg_write  in  1  register write enable
dmem_req  out  1  memory request (registered)
dmem_we  out  1  1=write (registered)
dmem_addr  out  32  word address: alu_out with [1:0] forced to 0 (registered)
dmem_be  out  4  byte enables (registered)
dmem_wdata  out  32  write data (registered)
dmem_rdata  in  32  read data, valid when dmem_ack=1
dmem_ack  in  1  access complete
stall  out  1  freeze IF/ID/EX (combinational)
branch_taken  out  1  is_branch & alu_zero (combinational)
pc_branch_out  out  32  pc_branch passthrough
reg_probe  out  5  forwarding: reg_addr
data_probe  out  32  forwarding: load data in DONE when mem_to_reg, else alu_out
write_probe  out  1  reg_write & (~mem_to_reg | state==DONE) & ~addr_err
wb_mem_to_reg  out  1  MEM/WB register
wb_reg_write  out  1  MEM/WB register
wb_reg_addr  out  5  MEM/WB register
wb_alu_out  out  32  MEM/WB register
wb_mem_data  out  32  MEM/WB register: formatted load data
addr_error  out  1  sticky misaligned-access flag
bus_error  out  1  sticky ack-timeout flag

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE, counter=0. All registered outputs are 0: dmem_*, wb_*, addr_error, bus_error. An in-flight request is dropped immediately and dmem_req falls without waiting for a clock edge.
- Definitions:
  - misaligned = (mem_read|mem_write) & ~mem_type & (alu_out[1:0]!=0)
  - access = (mem_read|mem_write) & ~misaligned
- Byte enables and write data:
  - Word: be=4'b1111, wdata=data_t.
  - Byte: be = 4'b0001<<alu_out[1:0], wdata = {4{data_t[7:0]}}.
- Load formatting:
  - Word: captured rdata.
  - Byte: lane alu_out[1:0] of rdata, sign-extended to 32 bits.
- FSM states:
  - IDLE:
    - If access: stall=1. Register dmem_req=1, dmem_we=mem_write, addr/be/wdata. Next state BUSY, counter=0.
    - Else: stall=0. If we, load MEM/WB.
    - If misaligned: set addr_error, load MEM/WB with wb_reg_write=0, issue no request, no stall.
  - BUSY:
    - stall=1; counter increments each cycle.
    - If dmem_ack: capture formatted load data, dmem_req=0, next state DONE.
    - Else if counter==TIMEOUT-1: set bus_error, dmem_req=0, load data=0, wb_reg_write forced 0 for this instruction, next state DONE.
  - DONE:
    - stall=0.
    - If we: load MEM/WB (wb_mem_data = captured data), next state IDLE.
    - Else: hold DONE.
- Minimum stall for a memory access is 2 cycles (IDLE, BUSY with immediate ack). The instruction leaves at the DONE edge, so EX presents the next instruction in the following IDLE cycle.
- dmem_ack outside BUSY is ignored.
- MEM/WB register holds its value when we=0 or stall=1.
- addr_error and bus_error clear only on reset.
- branch_taken and pc_branch_out are purely combinational; they are independent of stall and we.

Test Plan:
1. Word load at alu_out=0x1000, reg_addr=8; ack arrives in 3rd BUSY cycle with rdata=0xDEADBEEF -> stall high 4 cycles; wb_mem_data=0xDEADBEEF, wb_reg_addr=8, wb_reg_write=1.
2. Byte store at alu_out=0x1002, data_t=0x000000A5, immediate ack -> dmem_we=1, dmem_addr=0x1000, dmem_be=4'b0100, dmem_wdata=0xA5A5A5A5; stall exactly 2 cycles.
3. Byte load at alu_out=0x1003, rdata=0x80FF0000 -> wb_mem_data=0xFFFFFF80; with rdata=0x7F000000 -> 0x0000007F.
4. Word load at 0x1001 -> dmem_req stays 0, stall 0, addr_error=1, wb_reg_write=0.
5. Load with no ack, TIMEOUT=16 -> dmem_req high 16 cycles then 0; bus_error=1, wb_reg_write=0, pipeline resumes.
6. reset pulled low mid-BUSY, asynchronous to clk -> dmem_req and stall drop before next edge, state IDLE; separately, is_branch=1, alu_zero=1, pc_branch=0x400 -> branch_taken=1, pc_branch_out=0x400 same cycle.
